cgra_config_mem_responder: RTL and testbench

- Memory-side responder for the CGRA configuration-fetch read interface (mem_addr/mem_read/mem_rdata/mem_valid).
- Holds bitstream frames written by the host and returns one 64-bit frame per accepted read, after a fixed latency.
- Sits between the host/bus loader path and the config loader.
- Flags misaligned and out-of-range fetches without deadlocking the initiator.

---
 rtl/cgra_cfg_pkg.sv | 13 +
 rtl/cgra_cfg_sdp_ram.sv | 40 ++++
 rtl/cgra_config_mem_responder.sv | 138 +++++++++++++
 tb/tb_cgra_config_mem_responder.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/cgra_cfg_pkg.sv
// Shared types and constants for the CGRA configuration-memory responder.
package cgra_cfg_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } cfg_rsp_state_t;

    localparam int unsigned FRAME_BYTES = 8;
    localparam int unsigned FRAME_SHIFT = 3;

endpackage

// File: rtl/cgra_cfg_sdp_ram.sv
// Simple dual-port frame storage: host write port, registered read port that
// returns the pre-write contents when both ports hit the same index.
module cgra_cfg_sdp_ram #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 1024,
    localparam int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    input  logic             rd_zero_i,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic [WIDTH-1:0] rd_data_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_data_q;

    // Frame array write; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_idx_i] <= wr_data_i;
        end
    end

    // Read register; only updates on an issued read so it holds between responses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= rd_zero_i ? '0 : mem_q[rd_idx_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/cgra_config_mem_responder.sv
// Memory-side responder for CGRA configuration fetch: serves one frame per
// accepted read after READ_LATENCY cycles and flags bad addresses.
module cgra_config_mem_responder
    import cgra_cfg_pkg::*;
#(
    parameter int unsigned            CONFIG_WIDTH = 64,
    parameter int unsigned            ADDR_WIDTH   = 32,
    parameter int unsigned            DEPTH        = 1024,
    parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR    = '0,
    parameter int unsigned            READ_LATENCY = 2,
    localparam int unsigned           IDX_W        = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ADDR_WIDTH-1:0]   mem_addr,
    input  logic                    mem_read,
    output logic [CONFIG_WIDTH-1:0] mem_rdata,
    output logic                    mem_valid,
    input  logic                    host_wr_en,
    input  logic [IDX_W-1:0]        host_wr_idx,
    input  logic [CONFIG_WIDTH-1:0] host_wr_data,
    output logic                    resp_err,
    output logic                    err_sticky,
    output logic [ADDR_WIDTH-1:0]   err_addr,
    input  logic                    err_clr,
    output logic                    busy,
    output logic [15:0]             read_count
);

    localparam logic [3:0] LAT_INIT = 4'(READ_LATENCY - 1);

    cfg_rsp_state_t          state_q;
    logic [3:0]              lat_cnt_q;
    logic [ADDR_WIDTH-1:0]   req_addr_q;
    logic                    resp_err_q;
    logic                    err_sticky_q;
    logic [ADDR_WIDTH-1:0]   err_addr_q;
    logic [15:0]             read_count_q;

    logic [ADDR_WIDTH-1:0]   dec_addr_d;
    logic [ADDR_WIDTH-1:0]   dec_off_d;
    logic                    dec_bad_d;
    logic [IDX_W-1:0]        dec_idx_d;
    logic                    go_resp_d;

    // Offset is modular, so addresses below BASE_ADDR wrap high and fail the range test.
    function automatic logic addr_bad(input logic [ADDR_WIDTH-1:0] off);
        return (off[FRAME_SHIFT-1:0] != '0) ||
               ((off >> FRAME_SHIFT) >= ADDR_WIDTH'(DEPTH));
    endfunction

    // Decode the address being captured: live bus at latency 1, latched request otherwise.
    always_comb begin
        dec_addr_d = (state_q == IDLE) ? mem_addr : req_addr_q;
        dec_off_d  = dec_addr_d - BASE_ADDR;
        dec_bad_d  = addr_bad(dec_off_d);
        dec_idx_d  = dec_off_d[FRAME_SHIFT +: IDX_W];
        case (state_q)
            IDLE:    go_resp_d = mem_read && (READ_LATENCY == 32'd1);
            WAIT:    go_resp_d = mem_read && (lat_cnt_q == 4'd1);
            default: go_resp_d = 1'b0;
        endcase
    end

    // Request FSM, error tracking and served-frame counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            lat_cnt_q    <= 4'd0;
            req_addr_q   <= '0;
            resp_err_q   <= 1'b0;
            err_sticky_q <= 1'b0;
            err_addr_q   <= '0;
            read_count_q <= 16'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (mem_read) begin
                        req_addr_q <= mem_addr;
                        lat_cnt_q  <= LAT_INIT;
                        state_q    <= (READ_LATENCY == 32'd1) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    if (!mem_read) begin
                        state_q <= IDLE;
                    end else if (lat_cnt_q == 4'd1) begin
                        state_q <= RESP;
                    end else begin
                        lat_cnt_q <= lat_cnt_q - 4'd1;
                    end
                end
                RESP:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase

            resp_err_q <= go_resp_d && dec_bad_d;

            // A new error beats a simultaneous clear and records its own address.
            if (state_q == RESP && resp_err_q) begin
                err_sticky_q <= 1'b1;
                if (!err_sticky_q || err_clr) begin
                    err_addr_q <= req_addr_q;
                end
            end else if (err_clr) begin
                err_sticky_q <= 1'b0;
                err_addr_q   <= '0;
            end

            if (state_q == RESP) begin
                read_count_q <= read_count_q + 16'd1;
            end
        end
    end

    cgra_cfg_sdp_ram #(
        .WIDTH (CONFIG_WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en_i   (host_wr_en),
        .wr_idx_i  (host_wr_idx),
        .wr_data_i (host_wr_data),
        .rd_en_i   (go_resp_d),
        .rd_zero_i (dec_bad_d),
        .rd_idx_i  (dec_idx_d),
        .rd_data_o (mem_rdata)
    );

    assign mem_valid  = (state_q == RESP);
    assign busy       = (state_q != IDLE);
    assign resp_err   = resp_err_q;
    assign err_sticky = err_sticky_q;
    assign err_addr   = err_addr_q;
    assign read_count = read_count_q;

endmodule

// File: tb/tb_cgra_config_mem_responder.sv
// Scoreboard bench: three responders (latency 2, 1, 4; the last with a nonzero
// base) share host writes; one is selected at a time as the read target.
module tb_cgra_config_mem_responder;

    typedef struct {
        logic [63:0] data;
        logic        err;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] mem_addr;
    logic        mem_read_r;
    logic        host_wr_en;
    logic [9:0]  host_wr_idx;
    logic [63:0] host_wr_data;
    logic        err_clr;
    int          sel;
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    exp_t        sb_q[$];
    exp_t        mon_e;

    logic [63:0] rdata_w    [3];
    logic        valid_w    [3];
    logic        resp_err_w [3];
    logic        sticky_w   [3];
    logic [31:0] err_addr_w [3];
    logic        busy_w     [3];
    logic [15:0] rcnt_w     [3];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        cgra_config_mem_responder #(
            .READ_LATENCY ((g == 0) ? 2 : ((g == 1) ? 1 : 4)),
            .BASE_ADDR    ((g == 2) ? 32'h0000_1000 : 32'h0000_0000)
        ) u_dut (
            .clk          (clk),
            .rst_n        (rst_n),
            .mem_addr     (mem_addr),
            .mem_read     (mem_read_r && (sel == g)),
            .mem_rdata    (rdata_w[g]),
            .mem_valid    (valid_w[g]),
            .host_wr_en   (host_wr_en),
            .host_wr_idx  (host_wr_idx),
            .host_wr_data (host_wr_data),
            .resp_err     (resp_err_w[g]),
            .err_sticky   (sticky_w[g]),
            .err_addr     (err_addr_w[g]),
            .err_clr      (err_clr),
            .busy         (busy_w[g]),
            .read_count   (rcnt_w[g])
        );
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int lat_of(input int s);
        return (s == 0) ? 2 : ((s == 1) ? 1 : 4);
    endfunction

    function automatic logic [63:0] frame(input int i);
        return {32'hA5A5_0000, 32'(i)};
    endfunction

    // Every response is matched against the oldest expectation, including its cycle.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst_n && valid_w[i]) begin
                if (i != sel || sb_q.size() == 0) begin
                    chk("stray_valid", 64'(valid_w[i]), 64'd0);
                end else begin
                    mon_e = sb_q.pop_front();
                    chk("rdata", rdata_w[i], mon_e.data);
                    chk("resp_err", 64'(resp_err_w[i]), 64'(mon_e.err));
                    chk("latency", 64'(cyc), 64'(mon_e.cyc));
                end
            end
        end
    end

    // Called just after a rising edge; returns just after the edge that ends RESP.
    task automatic do_read(input logic [31:0] addr, input logic [63:0] exp_data,
                           input logic exp_err, input logic last, input logic clr_in_resp);
        exp_t e;
        bit   seen = 1'b0;
        mem_addr   = addr;
        mem_read_r = 1'b1;
        e.data = exp_data;
        e.err  = exp_err;
        e.cyc  = cyc + lat_of(sel);
        sb_q.push_back(e);
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            seen = valid_w[sel];
        end
        if (!seen) chk("timeout", 64'(seen), 64'd1);
        if (clr_in_resp) err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        if (last) mem_read_r = 1'b0;
    endtask

    task automatic host_wr(input int idx, input logic [63:0] d);
        host_wr_en   = 1'b1;
        host_wr_idx  = 10'(idx);
        host_wr_data = d;
        @(posedge clk); #1;
        host_wr_en   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; mem_addr = 32'd0; mem_read_r = 1'b0; host_wr_en = 1'b0;
        host_wr_idx = 10'd0; host_wr_data = 64'd0; err_clr = 1'b0; sel = 0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("rst_rdata", rdata_w[i], 64'd0);
            chk("rst_valid", 64'(valid_w[i]), 64'd0);
            chk("rst_resp_err", 64'(resp_err_w[i]), 64'd0);
            chk("rst_sticky", 64'(sticky_w[i]), 64'd0);
            chk("rst_err_addr", 64'(err_addr_w[i]), 64'd0);
            chk("rst_busy", 64'(busy_w[i]), 64'd0);
            chk("rst_count", 64'(rcnt_w[i]), 64'd0);
        end
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) host_wr(i, frame(i));

        // Sequential latency-2 reads of frames 0..15.
        sel = 0;
        for (int i = 0; i < 16; i++) do_read(32'(i * 8), frame(i), 1'b0, i == 15, 1'b0);
        chk("l2_count", 64'(rcnt_w[0]), 64'd16);
        chk("l2_sticky", 64'(sticky_w[0]), 64'd0);
        chk("l2_busy", 64'(busy_w[0]), 64'd0);

        // Back-to-back latency-1 reads.
        sel = 1;
        for (int i = 3; i < 9; i++) do_read(32'(i * 8), frame(i), 1'b0, i == 8, 1'b0);
        chk("l1_count", 64'(rcnt_w[1]), 64'd6);

        // Bad addresses, first-error capture, clear collision, plain clear.
        sel = 0;
        do_read(32'h4, 64'd0, 1'b1, 1'b1, 1'b0);
        chk("mis_sticky", 64'(sticky_w[0]), 64'd1);
        chk("mis_err_addr", 64'(err_addr_w[0]), 64'h4);
        do_read(32'h2000, 64'd0, 1'b1, 1'b1, 1'b0);
        chk("oor_sticky", 64'(sticky_w[0]), 64'd1);
        chk("oor_err_addr", 64'(err_addr_w[0]), 64'h4);
        do_read(32'h2008, 64'd0, 1'b1, 1'b1, 1'b1);
        chk("clrset_sticky", 64'(sticky_w[0]), 64'd1);
        chk("clrset_err_addr", 64'(err_addr_w[0]), 64'h2008);
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        chk("clr_sticky", 64'(sticky_w[0]), 64'd0);
        chk("clr_err_addr", 64'(err_addr_w[0]), 64'd0);
        chk("err_count", 64'(rcnt_w[0]), 64'd19);

        // Latency 4 with base 0x1000: good read, abort in WAIT, underflow.
        sel = 2;
        do_read(32'h1010, frame(2), 1'b0, 1'b1, 1'b0);
        mem_addr = 32'h1008; mem_read_r = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        mem_read_r = 1'b0;
        repeat (6) begin @(posedge clk); #1; end
        chk("abort_busy", 64'(busy_w[2]), 64'd0);
        chk("abort_count", 64'(rcnt_w[2]), 64'd1);
        do_read(32'h0FF8, 64'd0, 1'b1, 1'b1, 1'b0);
        chk("uflow_sticky", 64'(sticky_w[2]), 64'd1);
        chk("uflow_err_addr", 64'(err_addr_w[2]), 64'h0FF8);
        chk("uflow_count", 64'(rcnt_w[2]), 64'd2);

        // Host write in the capture cycle returns the old frame.
        sel = 0;
        host_wr(5, 64'h1111);
        fork
            do_read(32'h28, 64'h1111, 1'b0, 1'b1, 1'b0);
            begin
                @(posedge clk); #1;
                host_wr(5, 64'hDEAD);
            end
        join
        do_read(32'h28, 64'hDEAD, 1'b0, 1'b1, 1'b0);

        // One-cycle reset in the middle of WAIT.
        sel = 2;
        mem_addr = 32'h1018; mem_read_r = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b0; mem_read_r = 1'b0;
        @(posedge clk); #1;
        chk("mrst_rdata", rdata_w[2], 64'd0);
        chk("mrst_valid", 64'(valid_w[2]), 64'd0);
        chk("mrst_resp_err", 64'(resp_err_w[2]), 64'd0);
        chk("mrst_sticky", 64'(sticky_w[2]), 64'd0);
        chk("mrst_err_addr", 64'(err_addr_w[2]), 64'd0);
        chk("mrst_busy", 64'(busy_w[2]), 64'd0);
        chk("mrst_count", 64'(rcnt_w[2]), 64'd0);
        rst_n = 1'b1;
        repeat (8) begin @(posedge clk); #1; end
        do_read(32'h1018, frame(3), 1'b0, 1'b1, 1'b0);
        sel = 0;
        do_read(32'h28, 64'hDEAD, 1'b0, 1'b1, 1'b0);
        chk("post_rst_count", 64'(rcnt_w[0]), 64'd1);

        repeat (4) @(posedge clk);
        chk("sb_drain", 64'(sb_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
